// File: rtl/fu_branchpred_ctrl_if.sv
// Port bundle for fu_branchpred_ctrl: two branch-resolution requesters, flush control
// and the single BTB update port.
interface fu_branchpred_ctrl_if #(
    parameter int WORD_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic [WORD_W-1:0] req0_pc;
    logic [WORD_W-1:0] req0_target;
    logic              req0_taken;

    logic              req1_valid;
    logic              req1_ready;
    logic [WORD_W-1:0] req1_pc;
    logic [WORD_W-1:0] req1_target;
    logic              req1_taken;

    logic              flush_req;
    logic              flush_busy;
    logic              flush_done;
    logic              predict_enable;

    logic              btb_update;
    logic [WORD_W-1:0] btb_update_pc;
    logic [WORD_W-1:0] btb_branch_target;
    logic              btb_branch_outcome;

    modport master (
        output req0_valid, req0_pc, req0_target, req0_taken,
               req1_valid, req1_pc, req1_target, req1_taken,
               flush_req,
        input  req0_ready, req1_ready,
               flush_busy, flush_done, predict_enable,
               btb_update, btb_update_pc, btb_branch_target, btb_branch_outcome
    );

    modport slave (
        input  req0_valid, req0_pc, req0_target, req0_taken,
               req1_valid, req1_pc, req1_target, req1_taken,
               flush_req,
        output req0_ready, req1_ready,
               flush_busy, flush_done, predict_enable,
               btb_update, btb_update_pc, btb_branch_target, btb_branch_outcome
    );
endinterface

// File: rtl/fu_branchpred_ctrl.sv
// BTB update scheduler: two per-requester queues arbitrated round-robin onto the single
// BTB update port, plus a flush sequencer that walks and invalidates every BTB index.
module fu_branchpred_ctrl #(
    parameter int WORD_W     = 32,
    parameter int IDX_SIZE   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                CLK,
    input  logic                nRST,
    fu_branchpred_ctrl_if.slave bp
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]      PTR_ONE  = 1;
    localparam logic [PTR_W:0]      PTR_WRAP = {1'b1, {PTR_W{1'b0}}};
    localparam logic [IDX_SIZE-1:0] IDX_ONE  = 1;
    localparam logic [IDX_SIZE-1:0] IDX_LAST = '1;

    typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_DONE} state_t;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] target;
        logic              taken;
    } entry_t;

    state_t              r_state;
    logic [IDX_SIZE-1:0] r_idx;
    logic                r_rr;
    logic [PTR_W:0]      r_wr_ptr [2];
    logic [PTR_W:0]      r_rd_ptr [2];
    entry_t              r_mem    [2][FIFO_DEPTH];

    logic                r_btb_update;
    logic [WORD_W-1:0]   r_btb_update_pc;
    logic [WORD_W-1:0]   r_btb_branch_target;
    logic                r_btb_branch_outcome;
    logic                r_flush_busy;
    logic                r_flush_done;
    logic                r_predict_enable;

    entry_t              w_req [2];
    logic [1:0]          w_nonempty;
    logic [1:0]          w_full;
    logic [1:0]          w_ready;
    logic [1:0]          w_push;
    logic                w_pop;
    logic                w_grant;
    entry_t              w_head;
    logic [IDX_SIZE-1:0] w_idx_next;

    assign w_req[0]   = {bp.req0_pc, bp.req0_target, bp.req0_taken};
    assign w_req[1]   = {bp.req1_pc, bp.req1_target, bp.req1_taken};
    assign w_idx_next = r_idx + IDX_ONE;

    // NOTE: every signal below is assigned on every path through the block, so no latch is inferred.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            w_nonempty[n] = (r_wr_ptr[n] != r_rd_ptr[n]);
            w_full[n]     = (r_wr_ptr[n] == (r_rd_ptr[n] ^ PTR_WRAP));
            w_ready[n]    = !w_full[n] && (r_state == ST_RUN) && !bp.flush_req;
        end
        w_push[0] = bp.req0_valid && w_ready[0];
        w_push[1] = bp.req1_valid && w_ready[1];
        w_pop     = |w_nonempty;
        // Both pending: the pointer decides; otherwise the only non-empty queue wins.
        w_grant   = (&w_nonempty) ? r_rr : w_nonempty[1];
        w_head    = r_mem[w_grant][r_rd_ptr[w_grant][PTR_W-1:0]];
    end

    // NOTE: queue storage is deliberately not reset; the pointers alone define which entries are live.
    always_ff @(posedge CLK) begin
        if (w_push[0]) r_mem[0][r_wr_ptr[0][PTR_W-1:0]] <= w_req[0];
        if (w_push[1]) r_mem[1][r_wr_ptr[1][PTR_W-1:0]] <= w_req[1];
    end

    // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state              <= ST_RUN;
            r_idx                <= '0;
            r_rr                 <= 1'b0;
            r_btb_update         <= 1'b0;
            r_btb_update_pc      <= '0;
            r_btb_branch_target  <= '0;
            r_btb_branch_outcome <= 1'b0;
            r_flush_busy         <= 1'b0;
            r_flush_done         <= 1'b0;
            r_predict_enable     <= 1'b1;
            for (int n = 0; n < 2; n++) begin
                r_wr_ptr[n] <= '0;
                r_rd_ptr[n] <= '0;
            end
        end else begin
            r_btb_update <= 1'b0;
            r_flush_done <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (bp.flush_req) begin
                        // Drop everything queued and start the walk with index 0 next cycle.
                        for (int n = 0; n < 2; n++) r_rd_ptr[n] <= r_wr_ptr[n];
                        r_state              <= ST_FLUSH;
                        r_idx                <= '0;
                        r_btb_update         <= 1'b1;
                        r_btb_update_pc      <= '0;
                        r_btb_branch_target  <= '0;
                        r_btb_branch_outcome <= 1'b0;
                        r_flush_busy         <= 1'b1;
                        r_predict_enable     <= 1'b0;
                    end else begin
                        for (int n = 0; n < 2; n++) begin
                            if (w_push[n]) r_wr_ptr[n] <= r_wr_ptr[n] + PTR_ONE;
                        end
                        if (w_pop) begin
                            r_rd_ptr[w_grant]    <= r_rd_ptr[w_grant] + PTR_ONE;
                            r_rr                 <= ~w_grant;
                            r_btb_update         <= 1'b1;
                            r_btb_update_pc      <= w_head.pc;
                            r_btb_branch_target  <= w_head.target;
                            r_btb_branch_outcome <= w_head.taken;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (r_idx == IDX_LAST) begin
                        r_state      <= ST_DONE;
                        r_flush_busy <= 1'b0;
                        r_flush_done <= 1'b1;
                    end else begin
                        r_idx                <= w_idx_next;
                        r_btb_update         <= 1'b1;
                        r_btb_update_pc      <= WORD_W'({w_idx_next, 2'b00});
                        r_btb_branch_target  <= '0;
                        r_btb_branch_outcome <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state          <= ST_RUN;
                    r_predict_enable <= 1'b1;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign bp.req0_ready         = w_ready[0];
    assign bp.req1_ready         = w_ready[1];
    assign bp.flush_busy         = r_flush_busy;
    assign bp.flush_done         = r_flush_done;
    assign bp.predict_enable     = r_predict_enable;
    assign bp.btb_update         = r_btb_update;
    assign bp.btb_update_pc      = r_btb_update_pc;
    assign bp.btb_branch_target  = r_btb_branch_target;
    assign bp.btb_branch_outcome = r_btb_branch_outcome;
endmodule

// File: tb/tb_fu_branchpred_ctrl.sv
// Self-checking bench for fu_branchpred_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue-based reference model.
module tb_fu_branchpred_ctrl;
    localparam int WORD_W     = 32;
    localparam int IDX_SIZE   = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int N_IDX      = 1 << IDX_SIZE;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    fu_branchpred_ctrl_if #(.WORD_W(WORD_W)) bp ();

    fu_branchpred_ctrl #(
        .WORD_W    (WORD_W),
        .IDX_SIZE  (IDX_SIZE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_dut (
        .CLK (CLK),
        .nRST(nRST),
        .bp  (bp.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
    } ent_t;

    // Reference model: plain queues, a walk index (-1 when idle), a done flag, a fairness bit.
    ent_t        mq0[$];
    ent_t        mq1[$];
    int          m_idx;
    bit          m_done;
    bit          m_rr;
    logic        e_upd;
    logic [31:0] e_pc;
    logic [31:0] e_tgt;
    logic        e_out;
    logic        e_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int cnt_done = 0;
    int cnt_pe_low = 0;
    logic [31:0] obs_pc[$];
    logic        obs_out[$];
    int          obs_cyc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        m_idx  = -1;
        m_done = 1'b0;
        m_rr   = 1'b0;
        e_upd  = 1'b0;
        e_pc   = '0;
        e_tgt  = '0;
        e_out  = 1'b0;
        e_done = 1'b0;
    endtask

    task automatic model_step();
        ent_t e;
        bit   can0;
        bit   can1;
        e_upd  = 1'b0;
        e_done = 1'b0;
        if (m_done) begin
            m_done = 1'b0;
        end else if (m_idx >= 0) begin
            if (m_idx == N_IDX - 1) begin
                m_idx  = -1;
                m_done = 1'b1;
                e_done = 1'b1;
            end else begin
                m_idx++;
                e_upd = 1'b1;
                e_pc  = 32'(m_idx) << 2;
                e_tgt = '0;
                e_out = 1'b0;
            end
        end else if (bp.flush_req) begin
            mq0.delete();
            mq1.delete();
            m_idx = 0;
            e_upd = 1'b1;
            e_pc  = '0;
            e_tgt = '0;
            e_out = 1'b0;
        end else begin
            can0 = mq0.size() < FIFO_DEPTH;
            can1 = mq1.size() < FIFO_DEPTH;
            if (mq0.size() > 0 && (mq1.size() == 0 || !m_rr)) begin
                e = mq0.pop_front();
                m_rr = 1'b1;
                e_upd = 1'b1; e_pc = e.pc; e_tgt = e.target; e_out = e.taken;
            end else if (mq1.size() > 0) begin
                e = mq1.pop_front();
                m_rr = 1'b0;
                e_upd = 1'b1; e_pc = e.pc; e_tgt = e.target; e_out = e.taken;
            end
            if (bp.req0_valid && can0) mq0.push_back('{bp.req0_pc, bp.req0_target, bp.req0_taken});
            if (bp.req1_valid && can1) mq1.push_back('{bp.req1_pc, bp.req1_target, bp.req1_taken});
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge nRST);
            if (!nRST) model_reset();
            else       model_step();
        end
    end

    // Compare every cycle on the falling edge, and record what the DUT issued.
    always @(negedge CLK) begin : compare
        logic run;
        run = (m_idx < 0) && !m_done;
        cyc++;
        check("req0_ready", bp.req0_ready, run && (mq0.size() < FIFO_DEPTH) && !bp.flush_req);
        check("req1_ready", bp.req1_ready, run && (mq1.size() < FIFO_DEPTH) && !bp.flush_req);
        check("btb_update", bp.btb_update, e_upd);
        check("btb_update_pc", bp.btb_update_pc, e_pc);
        check("btb_branch_target", bp.btb_branch_target, e_tgt);
        check("btb_branch_outcome", bp.btb_branch_outcome, e_out);
        check("flush_busy", bp.flush_busy, m_idx >= 0);
        check("flush_done", bp.flush_done, e_done);
        check("predict_enable", bp.predict_enable, run);
        if (bp.btb_update === 1'b1) begin
            obs_pc.push_back(bp.btb_update_pc);
            obs_out.push_back(bp.btb_branch_outcome);
            obs_cyc.push_back(cyc);
        end
        if (bp.flush_done === 1'b1) cnt_done++;
        if (bp.predict_enable === 1'b0) cnt_pe_low++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic idle_inputs();
        bp.req0_valid = 1'b0; bp.req0_pc = '0; bp.req0_target = '0; bp.req0_taken = 1'b0;
        bp.req1_valid = 1'b0; bp.req1_pc = '0; bp.req1_target = '0; bp.req1_taken = 1'b0;
        bp.flush_req  = 1'b0;
    endtask

    task automatic random_traffic(input int n);
        for (int c = 0; c < n; c++) begin
            bp.req0_valid  = ($urandom_range(0, 99) < 60);
            bp.req0_pc     = $urandom;
            bp.req0_target = $urandom;
            bp.req0_taken  = 1'($urandom_range(0, 1));
            bp.req1_valid  = ($urandom_range(0, 99) < 60);
            bp.req1_pc     = $urandom;
            bp.req1_target = $urandom;
            bp.req1_taken  = 1'($urandom_range(0, 1));
            bp.flush_req   = ($urandom_range(0, 299) == 0);
            tick();
        end
        idle_inputs();
        ticks(N_IDX + 10);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        int b;
        int s0;
        int s1;
        int k0;
        int k1;
        int nz;
        int d0;
        int p0;
        bit saw_low0;
        logic r0;
        logic r1;
        logic [31:0] exp_cont [8];

        idle_inputs();
        nRST = 1'b0;
        ticks(3);
        check("rst_btb_update", bp.btb_update, 1'b0);
        check("rst_btb_pc", bp.btb_update_pc, 32'h0);
        check("rst_predict_enable", bp.predict_enable, 1'b1);
        check("rst_flush_busy", bp.flush_busy, 1'b0);
        check("rst_req0_ready", bp.req0_ready, 1'b1);
        nRST = 1'b1;
        ticks(2);

        // Contention: both requesters push four entries back to back.
        exp_cont = '{32'h10, 32'h20, 32'h14, 32'h24, 32'h18, 32'h28, 32'h1C, 32'h2C};
        b = obs_pc.size();
        for (int i = 0; i < 4; i++) begin
            bp.req0_valid = 1'b1; bp.req0_pc = 32'h10 + 32'(4 * i); bp.req0_target = 32'h100 + 32'(i); bp.req0_taken = 1'b1;
            bp.req1_valid = 1'b1; bp.req1_pc = 32'h20 + 32'(4 * i); bp.req1_target = 32'h200 + 32'(i); bp.req1_taken = 1'b0;
            tick();
        end
        idle_inputs();
        ticks(12);
        check("cont_count", obs_pc.size() - b, 8);
        if (obs_pc.size() - b == 8) begin
            for (int i = 0; i < 8; i++) check("cont_order", obs_pc[b + i], exp_cont[i]);
            check("cont_no_gap", obs_cyc[b + 7] - obs_cyc[b], 7);
        end

        // Single update with its two-cycle latency.
        b = obs_pc.size();
        bp.req0_valid = 1'b1; bp.req0_pc = 32'h100; bp.req0_target = 32'h80; bp.req0_taken = 1'b1;
        tick();
        idle_inputs();
        check("single_not_early", bp.btb_update, 1'b0);
        tick();
        check("single_update", bp.btb_update, 1'b1);
        check("single_pc", bp.btb_update_pc, 32'h100);
        check("single_target", bp.btb_branch_target, 32'h80);
        check("single_outcome", bp.btb_branch_outcome, 1'b1);
        tick();
        check("single_one_pulse", bp.btb_update, 1'b0);
        ticks(3);
        check("single_count", obs_pc.size() - b, 1);

        // Backpressure: req0 floods, req1 sends four; held entries must wait for ready.
        b = obs_pc.size();
        s0 = 0; s1 = 0; saw_low0 = 1'b0;
        for (int c = 0; c < 200 && (s0 < 16 || s1 < 4); c++) begin
            bp.req0_valid = (s0 < 16); bp.req0_pc = 32'h1000 + 32'(4 * s0); bp.req0_target = 32'(s0); bp.req0_taken = 1'b1;
            bp.req1_valid = (s1 < 4);  bp.req1_pc = 32'h2000 + 32'(4 * s1); bp.req1_target = 32'(s1); bp.req1_taken = 1'b0;
            @(negedge CLK);
            r0 = bp.req0_ready;
            r1 = bp.req1_ready;
            if (!r0 && bp.req0_valid) saw_low0 = 1'b1;
            @(posedge CLK);
            if (bp.req0_valid && r0) s0++;
            if (bp.req1_valid && r1) s1++;
            #1;
        end
        idle_inputs();
        ticks(20);
        check("bp_sent0", s0, 16);
        check("bp_sent1", s1, 4);
        check("bp_ready0_dropped", saw_low0, 1'b1);
        k0 = 0; k1 = 0;
        for (int i = b; i < obs_pc.size(); i++) begin
            if (obs_pc[i] < 32'h2000) begin
                check("bp_order0", obs_pc[i], 32'h1000 + 32'(4 * k0));
                k0++;
            end else begin
                check("bp_order1", obs_pc[i], 32'h2000 + 32'(4 * k1));
                k1++;
            end
        end
        check("bp_count0", k0, 16);
        check("bp_count1", k1, 4);

        // Full flush walk with exact flag timing.
        b = obs_pc.size(); d0 = cnt_done; p0 = cnt_pe_low;
        bp.flush_req = 1'b1;
        tick();
        bp.flush_req = 1'b0;
        check("flush_busy_first", bp.flush_busy, 1'b1);
        check("flush_pe_first", bp.predict_enable, 1'b0);
        check("flush_pc_first", bp.btb_update_pc, 32'h0);
        check("flush_ready_low", bp.req0_ready, 1'b0);
        ticks(N_IDX - 1);
        check("flush_pc_last", bp.btb_update_pc, 32'h3FC);
        check("flush_busy_last", bp.flush_busy, 1'b1);
        tick();
        check("flush_done_pulse", bp.flush_done, 1'b1);
        check("flush_done_no_update", bp.btb_update, 1'b0);
        check("flush_done_pe", bp.predict_enable, 1'b0);
        tick();
        check("flush_done_cleared", bp.flush_done, 1'b0);
        check("flush_pe_restored", bp.predict_enable, 1'b1);
        check("flush_ready_restored", bp.req0_ready, 1'b1);
        ticks(4);
        check("flush_update_count", obs_pc.size() - b, N_IDX);
        nz = 0;
        for (int i = b; i < obs_pc.size(); i++) if (obs_out[i] !== 1'b0) nz++;
        check("flush_outcome_zero", nz, 0);
        check("flush_done_count", cnt_done - d0, 1);
        check("flush_pe_low_cycles", cnt_pe_low - p0, N_IDX + 1);

        // Flush discards queued work, beats a same-cycle request and ignores a second pulse.
        for (int i = 0; i < 3; i++) begin
            bp.req0_valid = 1'b1; bp.req0_pc = 32'h3000 + 32'(4 * i); bp.req0_target = 32'h1; bp.req0_taken = 1'b1;
            bp.req1_valid = 1'b1; bp.req1_pc = 32'h4000 + 32'(4 * i); bp.req1_target = 32'h2; bp.req1_taken = 1'b1;
            tick();
        end
        bp.req0_valid = 1'b0;
        bp.req1_pc    = 32'h4FF0;
        bp.flush_req  = 1'b1;
        #1;
        check("conflict_ready1_low", bp.req1_ready, 1'b0);
        tick();
        idle_inputs();
        b = obs_pc.size(); d0 = cnt_done;
        ticks(99);
        bp.flush_req = 1'b1;
        tick();
        bp.flush_req = 1'b0;
        ticks(N_IDX - 100 + 6);
        check("conflict_update_count", obs_pc.size() - b, N_IDX);
        nz = 0;
        for (int i = b; i < obs_pc.size(); i++) if (obs_out[i] !== 1'b0) nz++;
        check("conflict_no_queued_updates", nz, 0);
        check("conflict_done_count", cnt_done - d0, 1);

        // Asynchronous reset in the middle of a walk.
        bp.flush_req = 1'b1;
        tick();
        bp.flush_req = 1'b0;
        ticks(49);
        check("midrst_busy_before", bp.flush_busy, 1'b1);
        nRST = 1'b0;
        #1;
        check("midrst_update", bp.btb_update, 1'b0);
        check("midrst_pe", bp.predict_enable, 1'b1);
        check("midrst_busy", bp.flush_busy, 1'b0);
        ticks(3);
        b = obs_pc.size();
        nRST = 1'b1;
        ticks(5);
        check("midrst_no_update", obs_pc.size() - b, 0);
        check("midrst_ready0", bp.req0_ready, 1'b1);
        check("midrst_ready1", bp.req1_ready, 1'b1);
        bp.req1_valid = 1'b1; bp.req1_pc = 32'h5000; bp.req1_target = 32'h5004; bp.req1_taken = 1'b1;
        tick();
        idle_inputs();
        ticks(3);
        check("midrst_run_count", obs_pc.size() - b, 1);
        if (obs_pc.size() - b == 1) check("midrst_run_pc", obs_pc[b], 32'h5000);

        // Randomized traffic, with one asynchronous reset between the two bursts.
        random_traffic(700);
        bp.req0_valid = 1'b1; bp.req0_pc = 32'h6000; bp.req1_valid = 1'b1; bp.req1_pc = 32'h7000;
        tick();
        nRST = 1'b0;
        ticks(2);
        idle_inputs();
        nRST = 1'b1;
        ticks(2);
        random_traffic(700);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fu_branchpred_ctrl.md
# fu_branchpred_ctrl

Update scheduler and flush sequencer for the branch target buffer (BTB) fetch-side predictor. It collects branch-resolution updates from two requesters, each with its own queue, and arbitrates them round-robin onto the BTB's single update port. On request it walks every BTB index to invalidate the table, for example on a kernel/context switch. During that walk it gates prediction use in fetch.

## Interface
- WORD_W, 32, PC/target width
- IDX_SIZE, 8, BTB index bits; the table has 2^IDX_SIZE entries
- FIFO_DEPTH, 4, entries per requester queue; power of two, ≥2
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- req0_valid / req1_valid  in  1  update request from resolver 0/1
- req0_ready / req1_ready  out  1  queue can accept this cycle
- req0_pc / req1_pc  in  WORD_W  resolved branch PC
- req0_target / req1_target  in  WORD_W  resolved branch target
- req0_taken / req1_taken  in  1  resolved outcome
- flush_req  in  1  single-cycle pulse: invalidate the whole BTB
- flush_busy  out  1  high while the flush walk is in progress
- flush_done  out  1  one-cycle pulse when the walk completes
- predict_enable  out  1  fetch may use BTB predictions
- btb_update  out  1  drives the BTB update strobe
- btb_update_pc  out  WORD_W  drives the BTB update PC
- btb_branch_target  out  WORD_W  drives the BTB update target
- btb_branch_outcome  out  1  drives the BTB update outcome (0 = invalidate)

## Operation
- **States:** RUN, FLUSH, DONE. Reset enters RUN.
- **Reset values:**
  - All btb_* outputs 0; flush_busy 0; flush_done 0; predict_enable 1.
  - Queues empty; round-robin pointer favours requester 0.
- **Enqueue:**
  - reqN_ready = (queue N not full) && state==RUN && !flush_req.
  - Push occurs on valid && ready.
  - Ready depends only on the registered count, not on a same-cycle pop.
- **Arbitration (RUN):**
  - Each cycle with ≥1 non-empty queue, pop one head.
  - If both queues are non-empty, grant the requester the pointer names, then toggle the pointer to the other requester.
  - If only one queue is non-empty, grant it; the pointer moves to the other requester.
  - The popped entry is registered onto btb_* with btb_update=1 for exactly one cycle.
  - With no pop, btb_update=0 and the other btb_* outputs hold their values.
  - Throughput: 1 update per cycle.
- **Ordering:**
  - Per-requester FIFO order is preserved.
  - No cross-requester ordering guarantee beyond round-robin.
- **Flush:**
  - flush_req in RUN: at the next edge, discard both queues and clear any pending pop, then enter FLUSH with idx=0.
  - In FLUSH, each cycle drive:
    - btb_update=1
    - btb_branch_outcome=0
    - btb_update_pc = {zero, idx, 2'b00}
    - btb_branch_target=0
  - idx increments and wraps at 2^IDX_SIZE. When the last index has been issued, go to DONE.
  - DONE lasts one cycle: flush_done=1, btb_update=0. Then return to RUN.
- **Flag timing:**
  - flush_busy = (state==FLUSH).
  - predict_enable = (state==RUN); it is low in both FLUSH and DONE.
- **Flush conflicts:**
  - flush_req during FLUSH or DONE is ignored; it does not restart the walk.
  - flush_req in the same cycle as reqN_valid: flush wins and the request is not accepted (ready is low).

## Timing
- **Update latency:** push at edge k, queue previously empty and arbiter granting it → btb_update high in the cycle after edge k+1 (2-cycle latency).
- **Flush sequence:** flush_req sampled at edge k:
  - flush_busy high and invalidate of idx 0 in the cycle after edge k.
  - Last index (2^IDX_SIZE−1) issued after edge k+2^IDX_SIZE−1.
  - flush_done high after edge k+2^IDX_SIZE, for one cycle.
  - RUN and ready restored after edge k+2^IDX_SIZE+1.
- **Reset mid-operation** (mid-flush or with full queues): everything returns immediately and asynchronously to reset values, and no further btb_update is issued.
- **Queue pointers:** wrap modulo FIFO_DEPTH. Full vs. empty is distinguished by an extra count bit.

## Test plan
- **Single update:** req0 {pc=0x100, target=0x80, taken=1} for one cycle → exactly one btb_update pulse 2 cycles later carrying 0x100/0x80/1.
- **Contention:** both requesters push every cycle, 4 entries each (req0 pc 0x10..0x1C, req1 pc 0x20..0x2C) → 8 consecutive updates alternating 0x10,0x20,0x14,0x24,...; no gaps, no loss.
- **Backpressure:** hold btb contention with req1 pushing 4 entries while req0 floods → reqN_ready drops when its queue holds FIFO_DEPTH entries; the entry held during !ready is not accepted; order is preserved after ready returns.
- **Flush walk:** pulse flush_req with IDX_SIZE=8 → exactly 256 btb_update cycles, update_pc 0x000,0x004,...,0x3FC, outcome=0; flush_done pulses once at cycle 257; predict_enable low from cycle 1 through 257.
- **Flush discard and conflict:** 3 queued req0 entries, then flush_req in the same cycle as req1_valid → none of the 4 updates appear; a second flush_req at walk cycle 100 is ignored, so the total stays 256 cycles.
- **Reset mid-flush:** nRST low at walk cycle 50 → btb_update=0 and predict_enable=1 immediately; after release, state is RUN and queues are empty.
